// File: rtl/game_pkg.sv
// Shared types and constants for the cat-vs-dog turn scheduler.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_WAIT,
    ST_CHARGE,
    ST_FLIGHT,
    ST_RESOLVE,
    ST_SWITCH,
    ST_OVER
  } sched_state_t;

  localparam int unsigned WIND_CALM = 50;
  localparam int unsigned WIND_MAX  = 100;
  localparam int unsigned FORCE_W   = 10;
  localparam int unsigned WIND_W    = 7;
  localparam int unsigned HP_W      = 3;

  localparam logic PLAYER_CAT = 1'b0;
  localparam logic PLAYER_DOG = 1'b1;

  // Folds 0..127 into 0..100; 101..127 land on 74..100.
  function automatic logic [WIND_W-1:0] wind_map(input logic [6:0] l);
    return (l > 7'(WIND_MAX)) ? l - 7'd27 : l;
  endfunction

endpackage

// File: rtl/throw_turn_sched_if.sv
// Scheduler <-> throw controller bundle: enables, force/wind and controller status.
interface throw_turn_sched_if;
  import game_pkg::*;

  logic                enable_cat;
  logic                enable_dog;
  logic [FORCE_W-1:0]  throw_force;
  logic [WIND_W-1:0]   wind_force;
  logic                throw_done_cat;
  logic                throw_done_dog;
  logic                hit_cat;
  logic                hit_dog;

  modport master (
    output enable_cat, enable_dog, throw_force, wind_force,
    input  throw_done_cat, throw_done_dog, hit_cat, hit_dog
  );

  modport slave (
    input  enable_cat, enable_dog, throw_force, wind_force,
    output throw_done_cat, throw_done_dog, hit_cat, hit_dog
  );

endinterface

// File: rtl/wind_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); wind sampled on draw.
module wind_lfsr
  import game_pkg::*;
#(
  parameter logic [7:0] WIND_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              draw,
  output logic [WIND_W-1:0] wind_force
);

  logic [7:0] lfsr;
  logic       fb;

  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= WIND_SEED;
      wind_force <= WIND_W'(WIND_CALM);
    end else begin
      lfsr <= {lfsr[6:0], fb};
      if (draw) begin
        wind_force <= wind_map(lfsr[6:0]);
      end
    end
  end

endmodule

// File: rtl/throw_turn_sched.sv
// Turn scheduler: alternates cat/dog turns, charges throw force, routes the
// throw to one controller at a time and tracks hit points to game over.
module throw_turn_sched
  import game_pkg::*;
#(
  parameter int unsigned FORCE_MAX           = 1000,
  parameter int unsigned FORCE_STEP_CYCLES   = 65000,
  parameter int unsigned HP_INIT             = 3,
  parameter int unsigned TURN_TIMEOUT_CYCLES = 650000000,
  parameter logic [7:0]  WIND_SEED           = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            btn_throw,
  throw_turn_sched_if.master ctl,
  output logic            turn,
  output logic [HP_W-1:0] hp_cat,
  output logic [HP_W-1:0] hp_dog,
  output logic            game_over,
  output logic            winner
);

  localparam int unsigned TO_W = (TURN_TIMEOUT_CYCLES > 1) ? $clog2(TURN_TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW   = (FORCE_STEP_CYCLES > 1) ? $clog2(FORCE_STEP_CYCLES) : 1;

  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TURN_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]      STEP_LAST = SW'(FORCE_STEP_CYCLES - 1);
  localparam logic [FORCE_W-1:0] F_MAX     = FORCE_W'(FORCE_MAX);
  localparam logic [HP_W-1:0]    HP_START  = HP_W'(HP_INIT);

  sched_state_t    state;
  logic            btn_prev;
  logic [TO_W-1:0] to_cnt;
  logic [SW-1:0]   step_cnt;
  logic            hit_flag;

  logic            btn_rise;
  logic            active_done;
  logic            active_hit;
  logic            new_game;
  logic            draw;
  logic [HP_W-1:0] opp_hp;
  logic [HP_W-1:0] opp_hp_next;

  assign btn_rise = btn_throw & ~btn_prev;

  always_comb begin
    active_done = (turn == PLAYER_DOG) ? ctl.throw_done_dog : ctl.throw_done_cat;
    active_hit  = (turn == PLAYER_DOG) ? ctl.hit_dog : ctl.hit_cat;
    opp_hp      = (turn == PLAYER_DOG) ? hp_cat : hp_dog;
    opp_hp_next = opp_hp;
    if (hit_flag && (opp_hp != '0)) begin
      opp_hp_next = opp_hp - HP_W'(1);
    end
    new_game = ((state == ST_IDLE) || (state == ST_OVER)) && start;
    // Wind is redrawn exactly on the edges that enter TURN_WAIT.
    draw     = new_game || ((state == ST_SWITCH) && !active_done);
  end

  wind_lfsr #(
    .WIND_SEED(WIND_SEED)
  ) u_wind (
    .clk        (clk),
    .rst        (rst),
    .draw       (draw),
    .wind_force (ctl.wind_force)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      ctl.enable_cat  <= 1'b0;
      ctl.enable_dog  <= 1'b0;
      ctl.throw_force <= '0;
      turn            <= PLAYER_CAT;
      hp_cat          <= HP_START;
      hp_dog          <= HP_START;
      game_over       <= 1'b0;
      winner          <= 1'b0;
      btn_prev        <= 1'b0;
      to_cnt          <= '0;
      step_cnt        <= '0;
      hit_flag        <= 1'b0;
    end else begin
      btn_prev <= btn_throw;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (new_game) begin
            state     <= ST_TURN_WAIT;
            turn      <= PLAYER_CAT;
            hp_cat    <= HP_START;
            hp_dog    <= HP_START;
            game_over <= 1'b0;
            to_cnt    <= '0;
            hit_flag  <= 1'b0;
          end
        end

        ST_TURN_WAIT: begin
          if (btn_rise) begin
            state           <= ST_CHARGE;
            ctl.throw_force <= '0;
            to_cnt          <= '0;
            step_cnt        <= '0;
          end else if (to_cnt == TO_LAST) begin
            state  <= ST_SWITCH;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_CHARGE: begin
          if (!btn_throw) begin
            state    <= ST_FLIGHT;
            hit_flag <= 1'b0;
            if (turn == PLAYER_DOG) begin
              ctl.enable_dog <= 1'b1;
            end else begin
              ctl.enable_cat <= 1'b1;
            end
          end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            if (ctl.throw_force < F_MAX) begin
              ctl.throw_force <= ctl.throw_force + FORCE_W'(1);
            end
          end else begin
            step_cnt <= step_cnt + SW'(1);
          end
        end

        ST_FLIGHT: begin
          // A hit arriving together with throw_done is still latched here.
          if (active_hit) begin
            hit_flag <= 1'b1;
          end
          if (active_done) begin
            state          <= ST_RESOLVE;
            ctl.enable_cat <= 1'b0;
            ctl.enable_dog <= 1'b0;
          end
        end

        ST_RESOLVE: begin
          hit_flag <= 1'b0;
          if (turn == PLAYER_DOG) begin
            hp_cat <= opp_hp_next;
          end else begin
            hp_dog <= opp_hp_next;
          end
          if (opp_hp_next == '0) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            winner    <= turn;
          end else begin
            state <= ST_SWITCH;
          end
        end

        ST_SWITCH: begin
          if (!active_done) begin
            state  <= ST_TURN_WAIT;
            turn   <= ~turn;
            to_cnt <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  enables_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ctl.enable_cat && ctl.enable_dog));

endmodule

// File: tb/tb_throw_turn_sched.sv
// Bench for throw_turn_sched: table-driven turns, hand sequences and random games
// checked against a turn-level game model.
module tb_throw_turn_sched;
  import game_pkg::*;

  localparam int unsigned FSC  = 4;
  localparam int unsigned TTO  = 100;
  localparam int unsigned HPI  = 2;
  localparam int unsigned FMAX = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       btn_throw = 1'b0;
  logic       turn, game_over, winner;
  logic [2:0] hp_cat, hp_dog;

  logic       w_rst = 1'b0;
  logic       w_draw = 1'b0;
  logic [6:0] w_wind;

  throw_turn_sched_if ctl();

  always #5 clk = ~clk;

  throw_turn_sched #(
    .FORCE_MAX           (FMAX),
    .FORCE_STEP_CYCLES   (FSC),
    .HP_INIT             (HPI),
    .TURN_TIMEOUT_CYCLES (TTO),
    .WIND_SEED           (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .btn_throw (btn_throw),
    .ctl       (ctl),
    .turn      (turn),
    .hp_cat    (hp_cat),
    .hp_dog    (hp_dog),
    .game_over (game_over),
    .winner    (winner)
  );

  wind_lfsr #(.WIND_SEED(8'hA5)) u_wind_ref (
    .clk        (clk),
    .rst        (w_rst),
    .draw       (w_draw),
    .wind_force (w_wind)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // LFSR state sequence from the seed, and the 0..100 wind rule.
  logic [7:0] seq [0:65535];

  function automatic int wmap(input logic [7:0] s);
    int l;
    l = int'(s[6:0]);
    return (l > 100) ? l - 27 : l;
  endfunction

  int edge_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic int exp_wind();
    return wmap(seq[(edge_cnt - 1) & 16'hFFFF]);
  endfunction

  // Continuous invariants: exclusive enables, wind range, force/wind frozen while enabled.
  int         inv_bad = 0;
  logic       pen = 1'b0;
  logic [9:0] pf;
  logic [6:0] pw;
  always @(negedge clk) begin
    if (!rst) begin
      if (ctl.enable_cat && ctl.enable_dog) inv_bad++;
      if (ctl.wind_force > 7'd100) inv_bad++;
      if (pen && (ctl.enable_cat || ctl.enable_dog) &&
          (ctl.throw_force != pf || ctl.wind_force != pw)) inv_bad++;
    end
    pen = ctl.enable_cat || ctl.enable_dog;
    pf  = ctl.throw_force;
    pw  = ctl.wind_force;
  end

  // Game model: whose turn, hit points, outcome.
  bit m_turn;
  int m_hp [2];
  bit m_over;
  bit m_winner;

  task automatic check_state(input string tag);
    check({tag, "_turn"}, turn, m_turn);
    check({tag, "_hp_cat"}, hp_cat, m_hp[0]);
    check({tag, "_hp_dog"}, hp_dog, m_hp[1]);
    check({tag, "_game_over"}, game_over, m_over);
    if (m_over) check({tag, "_winner"}, winner, m_winner);
  endtask

  task automatic set_done(input bit side, input bit v);
    if (side) ctl.throw_done_dog = v;
    else      ctl.throw_done_cat = v;
  endtask

  task automatic set_hit(input bit side, input bit v);
    if (side) ctl.hit_dog = v;
    else      ctl.hit_cat = v;
  endtask

  function automatic logic en_of(input bit side);
    return side ? ctl.enable_dog : ctl.enable_cat;
  endfunction

  task automatic start_game(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_turn = 1'b0;
    m_hp[0] = HPI;
    m_hp[1] = HPI;
    m_over = 1'b0;
    check_state(tag);
    check({tag, "_wind"}, ctl.wind_force, exp_wind());
  endtask

  // One turn from TURN_WAIT; hold == 0 means no press (forfeit by timeout).
  task automatic play_turn(input string tag, input int hold, input bit hit_act,
                           input bit hit_inact, input bit hit_at_done, input int flight);
    bit side;
    int waited;
    int ef;
    bit en_seen;
    side = m_turn;
    if (hold == 0) begin
      waited = 0;
      en_seen = 1'b0;
      while (turn == side && waited < 200) begin
        @(negedge clk);
        waited++;
        en_seen |= ctl.enable_cat | ctl.enable_dog;
      end
      check({tag, "_forfeit_timing"}, (waited >= 95 && waited <= 102), 1);
      check({tag, "_forfeit_no_enable"}, en_seen, 0);
      m_turn = ~side;
      check_state(tag);
      check({tag, "_wind"}, ctl.wind_force, exp_wind());
    end else begin
      ef = (hold - 1) / FSC;
      if (ef > FMAX) ef = FMAX;
      btn_throw = 1'b1;
      repeat (hold) @(negedge clk);
      btn_throw = 1'b0;
      @(negedge clk);
      check({tag, "_en_active"}, en_of(side), 1);
      check({tag, "_en_other"}, en_of(!side), 0);
      check({tag, "_force"}, ctl.throw_force, ef);
      for (int k = 0; k < flight; k++) begin
        if (k == 0 && hit_inact) set_hit(!side, 1'b1);
        if (k == flight - 1 && hit_act && !hit_at_done) set_hit(side, 1'b1);
        @(negedge clk);
        set_hit(1'b0, 1'b0);
        set_hit(1'b1, 1'b0);
      end
      set_done(side, 1'b1);
      if (hit_act && hit_at_done) set_hit(side, 1'b1);
      @(negedge clk);
      set_hit(side, 1'b0);
      check({tag, "_en_drop"}, en_of(side), 0);
      if (hit_act) begin
        if (m_hp[!side] > 0) m_hp[!side]--;
        if (m_hp[!side] == 0) begin
          m_over = 1'b1;
          m_winner = side;
        end
      end
      repeat (3) @(negedge clk);
      check({tag, "_turn_held_while_done"}, turn, side);
      set_done(side, 1'b0);
      if (m_over) begin
        @(negedge clk);
        check_state(tag);
        check({tag, "_over_en"}, ctl.enable_cat | ctl.enable_dog, 0);
      end else begin
        waited = 0;
        while (turn == side && waited < 10) begin
          @(negedge clk);
          waited++;
        end
        m_turn = ~side;
        check_state(tag);
        check({tag, "_wind"}, ctl.wind_force, exp_wind());
      end
    end
  endtask

  typedef struct {
    int hold;
    bit hit_act;
    bit hit_inact;
    bit hit_at_done;
    int flight;
    int exp_force;
    int exp_hp_cat;
    int exp_hp_dog;
    int exp_turn;
    int exp_over;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    seq[0] = 8'hA5;
    for (int i = 1; i < 65536; i++)
      seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};

    //          hold act inact done flight force hpc hpd turn over
    vecs[0] = '{41,   0,  0,   0,   20,    10,   2,  2,  1,   0};
    vecs[1] = '{5000, 0,  1,   0,   6,     1000, 2,  2,  0,   0};
    vecs[2] = '{9,    1,  0,   0,   5,     2,    2,  1,  1,   0};
    vecs[3] = '{1,    1,  0,   1,   2,     0,    1,  1,  0,   0};
    vecs[4] = '{13,   0,  1,   0,   4,     3,    1,  1,  1,   0};
    vecs[5] = '{0,    0,  0,   0,   0,     3,    1,  1,  0,   0};
    vecs[6] = '{5,    1,  0,   0,   3,     1,    1,  0,  0,   1};

    ctl.throw_done_cat = 1'b0;
    ctl.throw_done_dog = 1'b0;
    ctl.hit_cat = 1'b0;
    ctl.hit_dog = 1'b0;

    #2 rst = 1'b1;
    w_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_en_cat", ctl.enable_cat, 0);
    check("rst_en_dog", ctl.enable_dog, 0);
    check("rst_force", ctl.throw_force, 0);
    check("rst_wind", ctl.wind_force, 50);
    check("rst_turn", turn, 0);
    check("rst_hp_cat", hp_cat, HPI);
    check("rst_hp_dog", hp_dog, HPI);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    rst = 1'b0;
    w_rst = 1'b0;
    @(negedge clk);

    start_game("g1");
    for (int i = 0; i < 7; i++) begin
      play_turn($sformatf("vec%0d", i), vecs[i].hold, vecs[i].hit_act, vecs[i].hit_inact,
                vecs[i].hit_at_done, vecs[i].flight);
      check($sformatf("vec%0d_tbl_force", i), ctl.throw_force, vecs[i].exp_force);
      check($sformatf("vec%0d_tbl_hp_cat", i), hp_cat, vecs[i].exp_hp_cat);
      check($sformatf("vec%0d_tbl_hp_dog", i), hp_dog, vecs[i].exp_hp_dog);
      check($sformatf("vec%0d_tbl_turn", i), turn, vecs[i].exp_turn);
      check($sformatf("vec%0d_tbl_over", i), game_over, vecs[i].exp_over);
    end

    // Button is ignored once the game is over.
    btn_throw = 1'b1;
    repeat (20) @(negedge clk);
    btn_throw = 1'b0;
    repeat (3) @(negedge clk);
    check("over_btn_no_enable", ctl.enable_cat | ctl.enable_dog, 0);
    check_state("over_btn");

    // Restart with the button already held: that hold must not start a throw.
    btn_throw = 1'b1;
    @(negedge clk);
    start_game("restart");
    repeat (20) @(negedge clk);
    btn_throw = 1'b0;
    repeat (3) @(negedge clk);
    check("held_on_entry_no_enable", ctl.enable_cat | ctl.enable_dog, 0);

    // start during a running game is ignored.
    play_turn("mid", 9, 0, 0, 0, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_state("start_ignored");

    for (int r = 0; r < 40; r++) begin
      if (m_over) start_game($sformatf("rnd%0d_start", r));
      hold = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 60));
      play_turn($sformatf("rnd%0d", r), hold, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
    end

    // Reset while a throw is in flight.
    if (m_over) start_game("pre_rst");
    btn_throw = 1'b1;
    repeat (9) @(negedge clk);
    btn_throw = 1'b0;
    @(negedge clk);
    check("flight_before_rst", en_of(m_turn), 1);
    rst = 1'b1;
    #1;
    check("rst_flight_en_cat", ctl.enable_cat, 0);
    check("rst_flight_en_dog", ctl.enable_dog, 0);
    check("rst_flight_wind", ctl.wind_force, 50);
    check("rst_flight_turn", turn, 0);
    check("rst_flight_hp_cat", hp_cat, HPI);
    check("rst_flight_hp_dog", hp_dog, HPI);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    btn_throw = 1'b1;
    repeat (3) @(negedge clk);
    btn_throw = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_rst_no_enable", ctl.enable_cat | ctl.enable_dog, 0);

    // 1000 consecutive wind draws from a fresh LFSR.
    w_rst = 1'b1;
    @(negedge clk);
    w_rst = 1'b0;
    w_draw = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check($sformatf("draw%0d", i), w_wind, wmap(seq[i]));
    end
    w_draw = 1'b0;

    check("invariant_violations", inv_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/throw_turn_sched.md
Name: throw_turn_sched

Overview:
Turn scheduler for the cat-vs-dog throwing game. It alternates turns between the cat and dog players and measures throw force while the throw button is held. It draws a new wind value each turn, gives the shared throw/wind inputs to exactly one throw controller (cat or dog) at a time, and tracks hit points until one side loses. It sits between the input/UI logic and the two throw controllers.

Parameters:
FORCE_MAX, 1000, saturation value of throw_force (must fit 10 bits)
FORCE_STEP_CYCLES, 65000, clk cycles per +1 force increment while charging
HP_INIT, 3, starting hit points per player (1..7)
TURN_TIMEOUT_CYCLES, 650000000, idle cycles in TURN_WAIT before the turn is forfeited
WIND_SEED, 8'hA5, LFSR reset value (nonzero)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: begin or restart a game
btn_throw  in  1  throw button level, already synchronized/debounced
throw_done_cat  in  1  cat throw controller finished (level, held until its enable drops)
throw_done_dog  in  1  dog throw controller finished
hit_cat  in  1  pulse: cat projectile hit the dog
hit_dog  in  1  pulse: dog projectile hit the cat
enable_cat  out  1  run cat throw controller
enable_dog  out  1  run dog throw controller
throw_force  out  10  force to active controller, 0..FORCE_MAX
wind_force  out  7  wind for the current turn, 0..100 (50 = calm)
turn  out  1  0 = cat, 1 = dog
hp_cat  out  3  cat hit points
hp_dog  out  3  dog hit points
game_over  out  1  game finished
winner  out  1  0 = cat won, 1 = dog won; valid while game_over

Behaviour:
- Reset (async): state IDLE; enables 0, throw_force 0, wind_force 50, turn 0, hp_cat = hp_dog = HP_INIT, game_over 0, winner 0, LFSR = WIND_SEED, all counters 0. All outputs are registered.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk cycle.
- Wind draw: wind_force <= (l > 100) ? l - 27 : l, where l = lfsr[6:0]. Result is always 0..100.
- States: IDLE, TURN_WAIT, CHARGE, FLIGHT, RESOLVE, SWITCH, OVER.
- IDLE: on start -> TURN_WAIT. Set turn = 0, reload both HP, draw wind, clear game_over.
- TURN_WAIT: timeout counter increments each cycle.
  - Rising edge of btn_throw (edge detected against the previous cycle's level) -> CHARGE; throw_force <= 0, timeout counter cleared.
  - Counter reaches TURN_TIMEOUT_CYCLES-1 -> SWITCH (forfeit, no throw).
  - A button already held on entry does not count; a new edge is required.
- CHARGE: step counter wraps at FORCE_STEP_CYCLES-1; on each wrap throw_force += 1, saturating at FORCE_MAX.
  - btn_throw low -> FLIGHT; throw_force frozen.
- FLIGHT: enable of the active side (per turn) is 1 from the first FLIGHT cycle; the other enable stays 0.
  - A hit pulse from the active side sets hit_flag; hit pulses from the inactive side are ignored.
  - Active throw_done = 1 -> RESOLVE; the enable drops in the same transition.
- RESOLVE (1 cycle):
  - If hit_flag, opponent hp -= 1, saturating at 0. Clear hit_flag.
  - Opponent hp reaching 0 -> OVER with winner = turn. Otherwise -> SWITCH.
  - A hit pulse arriving in the same cycle as throw_done still counts.
- SWITCH: wait until the active throw_done = 0 (controller back in idle). Then toggle turn, draw new wind, -> TURN_WAIT.
- OVER: game_over = 1, enables 0. start -> IDLE-equivalent restart (same actions as IDLE on start, direct to TURN_WAIT).
- start in any state other than IDLE/OVER is ignored.
- Invariant: enable_cat & enable_dog is never 1. throw_force and wind_force are stable while either enable is high.
- Reset mid-flight: enables drop immediately (async), game returns to IDLE.

Decomposition:
- Package game_pkg: typedef enum sched_state_t; constants WIND_CALM = 50, WIND_MAX = 100, FORCE_W = 10, WIND_W = 7, HP_W = 3, PLAYER_CAT = 0, PLAYER_DOG = 1.
- Sub-module wind_lfsr: 8-bit LFSR plus the 0..100 mapping. Ports clk, rst, draw, wind_force[6:0]; wind updates on draw.

Test Plan:
- (Scenarios use FORCE_STEP_CYCLES=4, TURN_TIMEOUT_CYCLES=100, HP_INIT=2.)
- start, hold btn 41 cycles, release -> throw_force = 10, enable_cat high next cycle, enable_dog 0; throw_done_cat after 20 cycles -> enable_cat low, turn becomes 1 once done drops.
- Hold btn 5000 cycles -> throw_force saturates at 1000, no wrap.
- Cat turn with hit_cat pulse during FLIGHT -> hp_dog 2→1. hit_dog pulse during cat FLIGHT -> hp_cat unchanged.
- No press for 100 cycles in TURN_WAIT -> turn toggles, no enable asserted, HP unchanged, new wind drawn.
- Cat hits twice across two cat turns -> hp_dog = 0, game_over = 1, winner = 0; btn ignored; start -> hp both 2, turn 0, game_over 0.
- Assert rst during FLIGHT -> enable_cat 0 in the same cycle, state IDLE, wind_force 50. Over 1000 draws, wind_force is always ≤100 and the two enables are never high together.
